// File: rtl/register_load_arbiter_pkg.sv
// Shared types and helpers for the register load arbiter.
package register_load_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam int unsigned N_DEF    = 4;
  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned NREG_DEF = 8;
  localparam int unsigned AW_DEF   = 3;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/register_load_arbiter_rr_priority_picker.sv
// Round-robin picker: first requester at or after the pointer, wrapping at NREQ.
module rr_priority_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win_c,
  output logic            valid_c
);

  always_comb begin
    int unsigned j;
    win_c   = '0;
    valid_c = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!valid_c && req[j]) begin
        win_c[j] = 1'b1;
        valid_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_load_arbiter.sv
// Arbitrates one write bus into a bank of edge-loaded registers with a
// setup / strobe / release sequence per write, round-robin between requesters.
module register_load_arbiter
  import register_load_arbiter_pkg::*;
#(
  parameter int unsigned N    = N_DEF,
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = AW_DEF
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [NREQ-1:0]   Req,
  input  logic [NREQ*AW-1:0] ReqAddr,
  input  logic [NREQ*N-1:0] ReqData,
  output logic [NREQ-1:0]   Ack,
  output logic              Err,
  output logic [NREQ-1:0]   Grant,
  output logic              Busy,
  output logic [N-1:0]      BusData,
  output logic [NREG-1:0]   LoadBus
);

  localparam int unsigned PW = (clog2(NREQ) > 0) ? clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    bus_data_q, bus_data_d;
  logic [NREG-1:0] load_q, load_d;

  logic [NREQ-1:0] win_c;
  logic            win_valid_c;
  logic [PW-1:0]   win_idx_c;
  logic [AW-1:0]   win_addr_c;
  logic [N-1:0]    win_data_c;
  logic            addr_invalid_c;

  rr_priority_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .req     (Req),
    .ptr     (ptr_q),
    .win_c   (win_c),
    .valid_c (win_valid_c)
  );

  // Index, address and data of the one-hot winner.
  always_comb begin
    win_idx_c  = '0;
    win_addr_c = '0;
    win_data_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_c[i]) begin
        win_idx_c  = PW'(i);
        win_addr_c = ReqAddr[i*AW +: AW];
        win_data_c = ReqData[i*N +: N];
      end
    end
  end

  assign addr_invalid_c = (32'(addr_q) >= NREG);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    grant_d    = grant_q;
    bus_data_d = bus_data_q;
    ack_d      = '0;
    err_d      = 1'b0;
    load_d     = '0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (win_valid_c) begin
          state_d    = ST_SETUP;
          grant_d    = win_c;
          idx_d      = win_idx_c;
          addr_d     = win_addr_c;
          bus_data_d = win_data_c;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        // Out-of-range addresses match no bit, so nothing is strobed.
        for (int unsigned r = 0; r < NREG; r++) begin
          load_d[r] = (32'(addr_q) == r);
        end
      end
      ST_STROBE: begin
        state_d = ST_RELEASE;
        ack_d   = grant_q;
        err_d   = addr_invalid_c;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      bus_data_q <= '0;
      load_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      bus_data_q <= bus_data_d;
      load_q     <= load_d;
    end
  end

  assign Ack     = ack_q;
  assign Err     = err_q;
  assign Grant   = grant_q;
  assign Busy    = busy_q;
  assign BusData = bus_data_q;
  assign LoadBus = load_q;

endmodule

// File: tb/tb_register_load_arbiter.sv
// Directed bench for register_load_arbiter with a six-register bank model.
module tb_register_load_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned NREQ = 4;
  localparam int unsigned NREG = 6;
  localparam int unsigned AW   = 3;

  logic              Clock;
  logic              Clear;
  logic [NREQ-1:0]   Req;
  logic [NREQ*AW-1:0] ReqAddr;
  logic [NREQ*N-1:0] ReqData;
  logic [NREQ-1:0]   Ack;
  logic              Err;
  logic [NREQ-1:0]   Grant;
  logic              Busy;
  logic [N-1:0]      BusData;
  logic [NREG-1:0]   LoadBus;

  int total;
  int bad;
  int load_pulses;
  int onehot_viol;
  logic [N-1:0]    regs_m [NREG];
  logic [NREG-1:0] load_prev;

  register_load_arbiter #(
    .N(N), .NREQ(NREQ), .NREG(NREG), .AW(AW)
  ) dut (
    .Clock   (Clock),
    .Clear   (Clear),
    .Req     (Req),
    .ReqAddr (ReqAddr),
    .ReqData (ReqData),
    .Ack     (Ack),
    .Err     (Err),
    .Grant   (Grant),
    .Busy    (Busy),
    .BusData (BusData),
    .LoadBus (LoadBus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Register bank model: each register captures BusData on the rising edge of its Load.
  initial begin
    load_prev   = '0;
    load_pulses = 0;
    for (int r = 0; r < NREG; r++) regs_m[r] = '0;
  end
  always @(LoadBus) begin
    for (int r = 0; r < NREG; r++) begin
      if (LoadBus[r] && !load_prev[r]) begin
        regs_m[r]   = BusData;
        load_pulses = load_pulses + 1;
      end
    end
    load_prev = LoadBus;
  end

  initial onehot_viol = 0;
  always @(negedge Clock) begin
    if ($countones(Grant) > 1 || $countones(LoadBus) > 1 || $countones(Ack) > 1)
      onehot_viol = onehot_viol + 1;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_clear();
    @(posedge Clock);
    #1;
    Clear   = 1'b1;
    Req     = '0;
    ReqAddr = '0;
    ReqData = '0;
    #3;
    Clear   = 1'b0;
  endtask

  task automatic test_reset();
    Clear = 1'b1; Req = '0; ReqAddr = '0; ReqData = '0;
    #3;
    total++; if (Ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", Ack); end
    total++; if (Err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", Err); end
    total++; if (Grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", Grant); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
    total++; if (BusData !== 4'h0) begin bad++; $display("FAIL reset_busdata got=%h want=0", BusData); end
    total++; if (LoadBus !== 6'b000000) begin bad++; $display("FAIL reset_loadbus got=%b want=000000", LoadBus); end
    #4;
    Clear = 1'b0;
  endtask

  task automatic test_single();
    do_clear();
    Req = 4'b0001; ReqAddr[0*AW +: AW] = 3'd3; ReqData[0*N +: N] = 4'hA;
    tick();
    total++; if (Grant !== 4'b0001) begin bad++; $display("FAIL single_setup_grant got=%b want=0001", Grant); end
    total++; if (BusData !== 4'hA) begin bad++; $display("FAIL single_setup_data got=%h want=a", BusData); end
    total++; if (LoadBus !== 6'b000000) begin bad++; $display("FAIL single_setup_load got=%b want=000000", LoadBus); end
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL single_setup_busy got=%b want=1", Busy); end
    tick();
    total++; if (LoadBus !== 6'b001000) begin bad++; $display("FAIL single_strobe_load got=%b want=001000", LoadBus); end
    total++; if (Ack !== 4'b0000) begin bad++; $display("FAIL single_strobe_ack got=%b want=0000", Ack); end
    tick();
    total++; if (LoadBus !== 6'b000000) begin bad++; $display("FAIL single_release_load got=%b want=000000", LoadBus); end
    total++; if (Ack !== 4'b0001) begin bad++; $display("FAIL single_release_ack got=%b want=0001", Ack); end
    total++; if (Err !== 1'b0) begin bad++; $display("FAIL single_release_err got=%b want=0", Err); end
    Req = 4'b0000;
    tick();
    total++; if (Ack !== 4'b0000) begin bad++; $display("FAIL single_idle_ack got=%b want=0000", Ack); end
    total++; if (Grant !== 4'b0000) begin bad++; $display("FAIL single_idle_grant got=%b want=0000", Grant); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", Busy); end
    total++; if (BusData !== 4'hA) begin bad++; $display("FAIL single_idle_hold got=%h want=a", BusData); end
    total++; if (regs_m[3] !== 4'hA) begin bad++; $display("FAIL single_reg3 got=%h want=a", regs_m[3]); end
  endtask

  task automatic test_all_requesting();
    logic [NREQ-1:0] exp_order [4];
    int n;
    int last;
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010;
    exp_order[2] = 4'b0100; exp_order[3] = 4'b1000;
    n = 0; last = -1;
    do_clear();
    ReqAddr = {3'd5, 3'd2, 3'd1, 3'd0};
    ReqData = {4'h5, 4'hC, 4'h7, 4'h1};
    Req = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (Ack !== 4'b0000) begin
        if (n < 4) begin
          total++;
          if (Ack !== exp_order[n]) begin bad++; $display("FAIL all_order[%0d] got=%b want=%b", n, Ack, exp_order[n]); end
        end
        if (n == 3) last = c;
        Req = Req & ~Ack;
        n++;
      end
    end
    total++; if (n !== 4) begin bad++; $display("FAIL all_ack_count got=%0d want=4", n); end
    total++; if (last !== 15) begin bad++; $display("FAIL all_last_ack_cycle got=%0d want=15", last); end
    total++; if (regs_m[0] !== 4'h1) begin bad++; $display("FAIL all_reg0 got=%h want=1", regs_m[0]); end
    total++; if (regs_m[1] !== 4'h7) begin bad++; $display("FAIL all_reg1 got=%h want=7", regs_m[1]); end
    total++; if (regs_m[2] !== 4'hC) begin bad++; $display("FAIL all_reg2 got=%h want=c", regs_m[2]); end
    total++; if (regs_m[5] !== 4'h5) begin bad++; $display("FAIL all_reg5 got=%h want=5", regs_m[5]); end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] exp_order [4];
    int n;
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0100;
    exp_order[2] = 4'b0001; exp_order[3] = 4'b0100;
    n = 0;
    do_clear();
    ReqAddr = {3'd0, 3'd2, 3'd0, 3'd0};
    ReqData = {4'h0, 4'h2, 4'h0, 4'h1};
    Req = 4'b0101;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (Ack !== 4'b0000) begin
        if (n < 4) begin
          total++;
          if (Ack !== exp_order[n]) begin bad++; $display("FAIL fair_order[%0d] got=%b want=%b", n, Ack, exp_order[n]); end
        end
        n++;
      end
    end
    total++; if (n !== 4) begin bad++; $display("FAIL fair_ack_count got=%0d want=4", n); end
    Req = 4'b0000;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_invalid_addr();
    int pulses0;
    do_clear();
    pulses0 = load_pulses;
    Req = 4'b0010; ReqAddr[1*AW +: AW] = 3'd7; ReqData[1*N +: N] = 4'hF;
    tick();
    total++; if (Grant !== 4'b0010) begin bad++; $display("FAIL inv_grant got=%b want=0010", Grant); end
    tick();
    total++; if (LoadBus !== 6'b000000) begin bad++; $display("FAIL inv_strobe_load got=%b want=000000", LoadBus); end
    tick();
    total++; if (Ack !== 4'b0010) begin bad++; $display("FAIL inv_ack got=%b want=0010", Ack); end
    total++; if (Err !== 1'b1) begin bad++; $display("FAIL inv_err got=%b want=1", Err); end
    Req = 4'b0000;
    tick();
    total++; if (Err !== 1'b0) begin bad++; $display("FAIL inv_err_clear got=%b want=0", Err); end
    total++; if (load_pulses - pulses0 !== 0) begin bad++; $display("FAIL inv_load_pulses got=%0d want=0", load_pulses - pulses0); end
  endtask

  task automatic test_clear_in_strobe();
    do_clear();
    Req = 4'b1000; ReqAddr[3*AW +: AW] = 3'd4; ReqData[3*N +: N] = 4'h6;
    tick();
    tick();
    total++; if (LoadBus !== 6'b010000) begin bad++; $display("FAIL clr_strobe_load got=%b want=010000", LoadBus); end
    #2;
    Clear = 1'b1;
    #1;
    total++; if (LoadBus !== 6'b000000) begin bad++; $display("FAIL clr_async_load got=%b want=000000", LoadBus); end
    total++; if (Grant !== 4'b0000) begin bad++; $display("FAIL clr_async_grant got=%b want=0000", Grant); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL clr_async_busy got=%b want=0", Busy); end
    total++; if (Ack !== 4'b0000) begin bad++; $display("FAIL clr_async_ack got=%b want=0000", Ack); end
    Req = 4'b1010; ReqAddr[1*AW +: AW] = 3'd1; ReqData[1*N +: N] = 4'h8;
    #1;
    Clear = 1'b0;
    tick();
    total++; if (Grant !== 4'b0010) begin bad++; $display("FAIL clr_first_grant got=%b want=0010", Grant); end
    tick();
    tick();
    total++; if (Ack !== 4'b0010) begin bad++; $display("FAIL clr_first_ack got=%b want=0010", Ack); end
    Req = 4'b0000;
    tick();
    total++; if (regs_m[1] !== 4'h8) begin bad++; $display("FAIL clr_reg1 got=%h want=8", regs_m[1]); end
  endtask

  task automatic test_data_change();
    do_clear();
    Req = 4'b0001; ReqAddr[0*AW +: AW] = 3'd1; ReqData[0*N +: N] = 4'h5;
    tick();
    ReqData[0*N +: N] = 4'h9;
    ReqAddr[0*AW +: AW] = 3'd2;
    tick();
    total++; if (BusData !== 4'h5) begin bad++; $display("FAIL chg_busdata got=%h want=5", BusData); end
    total++; if (LoadBus !== 6'b000010) begin bad++; $display("FAIL chg_load got=%b want=000010", LoadBus); end
    tick();
    total++; if (Ack !== 4'b0001) begin bad++; $display("FAIL chg_ack got=%b want=0001", Ack); end
    Req = 4'b0000;
    tick();
    total++; if (regs_m[1] !== 4'h5) begin bad++; $display("FAIL chg_reg1 got=%h want=5", regs_m[1]); end
  endtask

  task automatic test_onehot();
    total++; if (onehot_viol !== 0) begin bad++; $display("FAIL onehot_violations got=%0d want=0", onehot_viol); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_all_requesting();
    test_fairness();
    test_invalid_addr();
    test_clear_in_strobe();
    test_data_change();
    test_onehot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
